alu_muldiv_ctrl: RTL and testbench
==================================

Name: alu_muldiv_ctrl

Overview:
Next-generation ALU control for the multi-cycle MIPS core.
- Keeps the ALUOp/Funct to ALUConf/Sign decode, parametrised in data width.
- Adds an iterative multiply/divide engine with HI/LO registers, driven by a start/busy/done handshake.
- Sits beside the main ALU in the EX state; the main controller stalls while md_busy is high.

Parameters:
- WIDTH, 32, operand/HI/LO width (even, >=8)
- CONF_W, 5, ALUConf width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ALUOp  in  4  controller op class (0 ADD, 1 SUB, 2 FUNCT, 3 AND, 4 LU, 5 SLT, 6 ADDU, 7 SLTU)
- Funct  in  6  instruction funct field
- start  in  1  one-cycle request qualifying ALUOp/Funct/op_a/op_b for HI/LO operations
- op_a  in  WIDTH  rs value (dividend / multiplicand / mthi-mtlo source)
- op_b  in  WIDTH  rt value (divisor / multiplier)
- ALUConf  out  CONF_W  main ALU operation code (combinational)
- Sign  out  1  signed-operation flag (combinational)
- md_busy  out  1  engine occupied
- md_done  out  1  one-cycle pulse when HI/LO are updated by mult/div
- hilo_out  out  WIDTH  HI when Funct=0x10 (mfhi), otherwise LO (combinational)

Behaviour:
- Decode (combinational, unchanged semantics):
  - ALUOp 0→ADD(0), 1→SUB(1), 3→AND(2), 4→NOP2(0x10), 5→SLT(8), other→0.
  - ALUOp 2 by Funct:
    - 20/21→ADD, 22/23→SUB, 24→AND(2), 25→OR(3), 26→XOR(4), 27→NOR(5)
    - 00→SL(6), 02/03→SR(7), 2a/2b→SLT(8), 08/09→NOP1(9)
    - 10/11/12/13/18/19/1a/1b→ADD
    - other→0
- Sign = 0 for Funct 21, 23, 00, 02, 2b, 19 (multu), 1b (divu) under ALUOp 2, and for ALUOp 6 or 7; otherwise 1.
- Accepted request: start=1 and state IDLE and ALUOp=2 and Funct in {11,13,18,19,1a,1b}. start in any other state, or with any other op, is ignored with no side effect.
- mthi (11) / mtlo (13): HI/LO ← op_a at the accepting edge. No busy, no md_done.
- FSM states IDLE, MUL, DIV, DONE; md_busy = (state != IDLE).
- IDLE→MUL on accepted 18/19:
  - Latch operand magnitudes (absolute value when signed) and the result sign.
  - Count = WIDTH. Radix-2 shift-add runs one bit per cycle.
  - Count reaches 0 → DONE.
- IDLE→DIV on accepted 1a/1b with op_b≠0:
  - Restoring division, one quotient bit per cycle, WIDTH cycles → DONE.
- Divide by zero: IDLE→DONE directly. LO ← all ones, HI ← op_a.
- Signed results:
  - Product is the 2·WIDTH-bit two's complement value; HI = upper half, LO = lower half.
  - Quotient truncates toward zero.
  - Remainder takes the dividend's sign.
  - MIN / −1: LO = MIN, HI = 0.
- DONE: HI/LO written on entry edge; md_done=1 for exactly that cycle; →IDLE next cycle.
- Latency: accept at edge 0; md_busy high edges 1..WIDTH+1; md_done high in cycle WIDTH+1; new HI/LO visible on hilo_out that same cycle. Divide by zero: md_done in cycle 1.
- Back-to-back: start may be re-asserted in the first IDLE cycle after DONE.
- Reset:
  - HI=LO=0, state IDLE, md_busy=0, md_done=0, count=0.
  - Reset mid-operation aborts with no HI/LO update.
  - Reset has priority over start in the same cycle.
- hilo_out reflects registered HI/LO; reading during busy returns the old values.

Decomposition:
- Package alu_pkg:
  - ALUConf codes (ADD..NOP2), ALUOp codes (OP_ADD..OP_SLTU)
  - Funct constants (F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO, F_MTHI, F_MTLO, etc.)
  - FSM state encoding
- Sub-module md_iter_core holds the shared iterative datapath:
  - Operand/partial registers and counter
  - Ports: clk, reset, go, is_div, a, b, sgn, done, hi, lo
- Top holds decode, Sign, FSM and HI/LO registers.

Test Plan:
- Decode sweep: ALUOp=2 with each listed Funct, plus ALUOp 0..7 → exact ALUConf/Sign per table. Checks: Funct 19 → ADD, Sign 0; Funct 3f → 0, Sign 1.
- mult, WIDTH=32, op_a=0xFFFFFFFE (−2), op_b=3, start → busy for 33 cycles, md_done in cycle 33, HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with multu → HI=0x00000002, LO=0xFFFFFFFA.
- div op_a=−7, op_b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu op_a=7, op_b=2 → LO=3, HI=1. div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- divu op_b=0, op_a=0x1234 → md_done in cycle 1, LO=0xFFFFFFFF, HI=0x1234. Then mthi 0xA5A5A5A5 → HI updated next edge, md_busy stays 0.
- start (mult) re-asserted at cycle 5 of a running div → ignored; div result unchanged; md_done pulses exactly once.
- Reset asserted at cycle 10 of a mult → md_busy=0 next cycle, HI=LO=0, no md_done. A new mult issued after reset completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control / multiply-divide block.
`timescale 1ns/1ps
package alu_pkg;

   // Main ALU operation codes
   localparam logic [4:0] C_ADD  = 5'h00;
   localparam logic [4:0] C_SUB  = 5'h01;
   localparam logic [4:0] C_AND  = 5'h02;
   localparam logic [4:0] C_OR   = 5'h03;
   localparam logic [4:0] C_XOR  = 5'h04;
   localparam logic [4:0] C_NOR  = 5'h05;
   localparam logic [4:0] C_SL   = 5'h06;
   localparam logic [4:0] C_SR   = 5'h07;
   localparam logic [4:0] C_SLT  = 5'h08;
   localparam logic [4:0] C_NOP1 = 5'h09;
   localparam logic [4:0] C_NOP2 = 5'h10;

   // Controller op classes
   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_FUNCT = 4'd2;
   localparam logic [3:0] OP_AND   = 4'd3;
   localparam logic [3:0] OP_LU    = 4'd4;
   localparam logic [3:0] OP_SLT   = 4'd5;
   localparam logic [3:0] OP_ADDU  = 4'd6;
   localparam logic [3:0] OP_SLTU  = 4'd7;

   // Instruction funct field values
   localparam logic [5:0] F_SLL   = 6'h00;
   localparam logic [5:0] F_SRL   = 6'h02;
   localparam logic [5:0] F_SRA   = 6'h03;
   localparam logic [5:0] F_JR    = 6'h08;
   localparam logic [5:0] F_JALR  = 6'h09;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1a;
   localparam logic [5:0] F_DIVU  = 6'h1b;
   localparam logic [5:0] F_ADD   = 6'h20;
   localparam logic [5:0] F_ADDU  = 6'h21;
   localparam logic [5:0] F_SUB   = 6'h22;
   localparam logic [5:0] F_SUBU  = 6'h23;
   localparam logic [5:0] F_AND   = 6'h24;
   localparam logic [5:0] F_OR    = 6'h25;
   localparam logic [5:0] F_XOR   = 6'h26;
   localparam logic [5:0] F_NOR   = 6'h27;
   localparam logic [5:0] F_SLT   = 6'h2a;
   localparam logic [5:0] F_SLTU  = 6'h2b;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } md_state_t;

endpackage

// File: rtl/md_iter_core.sv
// Iterative radix-2 multiply / restoring divide datapath working on operand
// magnitudes. hi/lo present the sign-corrected result of the step taken at
// the coming edge, so the owner can capture them on the edge where done=1.
`timescale 1ns/1ps
module md_iter_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sgn,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0]   acc, q, m, acc_nx, q_nx;
   logic [CW-1:0]      cnt;
   logic               div_r, neg_q, neg_r;
   logic [WIDTH:0]     sum, shl, diff;
   logic [2*WIDTH-1:0] prod;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
      return (s && v[WIDTH-1]) ? -v : v;
   endfunction

   // One iteration step plus final sign correction of the would-be result
   always_comb begin
      sum  = {1'b0, acc} + {1'b0, (q[0] ? m : '0)};
      shl  = {acc, q[WIDTH-1]};
      diff = shl - {1'b0, m};
      if (div_r) begin
         if (!diff[WIDTH]) begin
            acc_nx = diff[WIDTH-1:0];
            q_nx   = {q[WIDTH-2:0], 1'b1};
         end else begin
            acc_nx = shl[WIDTH-1:0];
            q_nx   = {q[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_nx = sum[WIDTH:1];
         q_nx   = {sum[0], q[WIDTH-1:1]};
      end
      prod = {acc_nx, q_nx};
      if (neg_q) prod = -prod;
      if (div_r) begin
         hi = neg_r ? -acc_nx : acc_nx;
         lo = neg_q ? -q_nx : q_nx;
      end else begin
         hi = prod[2*WIDTH-1:WIDTH];
         lo = prod[WIDTH-1:0];
      end
      done = (cnt == CW'(1));
   end

   // Operand load on go, then one bit per cycle until the counter drains
   always_ff @(posedge clk) begin
      if (reset) begin
         acc   <= '0;
         q     <= '0;
         m     <= '0;
         cnt   <= '0;
         div_r <= 1'b0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (go) begin
         acc   <= '0;
         q     <= mag(a, sgn);
         m     <= mag(b, sgn);
         cnt   <= CW'(WIDTH);
         div_r <= is_div;
         neg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
         neg_r <= sgn & a[WIDTH-1];
      end else if (cnt != '0) begin
         acc <= acc_nx;
         q   <= q_nx;
         cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// ALU control decode plus HI/LO multiply/divide sequencing.
//
//   state  | meaning
//   S_IDLE | waiting for a mult/div/mthi/mtlo request
//   S_MUL  | shift-add multiply running in the core
//   S_DIV  | restoring divide running in the core
//   S_DONE | HI/LO just written, md_done high for this cycle
`timescale 1ns/1ps
module alu_muldiv_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int CONF_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        ALUOp,
   input  logic [5:0]        Funct,
   input  logic              start,
   input  logic [WIDTH-1:0]  op_a,
   input  logic [WIDTH-1:0]  op_b,
   output logic [CONF_W-1:0] ALUConf,
   output logic              Sign,
   output logic              md_busy,
   output logic              md_done,
   output logic [WIDTH-1:0]  hilo_out
);
   md_state_t        state;
   logic [WIDTH-1:0] hi_q, lo_q, core_hi, core_lo;
   logic [4:0]       conf;
   logic             is_mul, is_dv, accept, go, core_done;

   // Main ALU operation and sign decode
   always_comb begin
      conf = C_ADD;
      case (ALUOp)
         OP_ADD: conf = C_ADD;
         OP_SUB: conf = C_SUB;
         OP_AND: conf = C_AND;
         OP_LU:  conf = C_NOP2;
         OP_SLT: conf = C_SLT;
         OP_FUNCT: begin
            case (Funct)
               F_ADD, F_ADDU:  conf = C_ADD;
               F_SUB, F_SUBU:  conf = C_SUB;
               F_AND:          conf = C_AND;
               F_OR:           conf = C_OR;
               F_XOR:          conf = C_XOR;
               F_NOR:          conf = C_NOR;
               F_SLL:          conf = C_SL;
               F_SRL, F_SRA:   conf = C_SR;
               F_SLT, F_SLTU:  conf = C_SLT;
               F_JR, F_JALR:   conf = C_NOP1;
               default:        conf = C_ADD;
            endcase
         end
         default: conf = C_ADD;
      endcase
      Sign = 1'b1;
      if (ALUOp == OP_ADDU || ALUOp == OP_SLTU) Sign = 1'b0;
      if (ALUOp == OP_FUNCT && (Funct inside {F_ADDU, F_SUBU, F_SLL, F_SRL, F_SLTU, F_MULTU, F_DIVU}))
         Sign = 1'b0;
   end

   assign ALUConf  = CONF_W'(conf);
   assign hilo_out = (Funct == F_MFHI) ? hi_q : lo_q;
   assign is_mul   = (Funct == F_MULT) || (Funct == F_MULTU);
   assign is_dv    = (Funct == F_DIV)  || (Funct == F_DIVU);
   assign accept   = start && (state == S_IDLE) && (ALUOp == OP_FUNCT)
                     && (is_mul || is_dv || Funct == F_MTHI || Funct == F_MTLO);
   // Divide by zero never starts the core; its result is fixed
   assign go       = accept && (is_mul || (is_dv && op_b != '0));

   md_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .reset  (reset),
      .go     (go),
      .is_div (is_dv),
      .a      (op_a),
      .b      (op_b),
      .sgn    (~Funct[0]),
      .done   (core_done),
      .hi     (core_hi),
      .lo     (core_lo)
   );

   // Sequencing FSM owning HI/LO and the busy/done handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         md_busy <= 1'b0;
         md_done <= 1'b0;
      end else begin
         md_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (Funct == F_MTHI) begin
                     hi_q <= op_a;
                  end else if (Funct == F_MTLO) begin
                     lo_q <= op_a;
                  end else if (is_mul) begin
                     state   <= S_MUL;
                     md_busy <= 1'b1;
                  end else if (op_b == '0) begin
                     hi_q    <= op_a;
                     lo_q    <= '1;
                     state   <= S_DONE;
                     md_busy <= 1'b1;
                     md_done <= 1'b1;
                  end else begin
                     state   <= S_DIV;
                     md_busy <= 1'b1;
                  end
               end
            end
            S_MUL, S_DIV: begin
               if (core_done) begin
                  hi_q    <= core_hi;
                  lo_q    <= core_lo;
                  state   <= S_DONE;
                  md_done <= 1'b1;
               end
            end
            S_DONE: begin
               state   <= S_IDLE;
               md_busy <= 1'b0;
            end
            default: begin
               state   <= S_IDLE;
               md_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Scoreboard bench for alu_muldiv_ctrl (WIDTH=32).
`timescale 1ns/1ps
module tb_alu_muldiv_ctrl;
   import alu_pkg::*;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          due;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  aluop = 4'd0;
   logic [5:0]  funct_drv = 6'h12;
   logic [5:0]  funct_w;
   logic        rd_hi = 1'b0;
   logic [31:0] op_a = '0, op_b = '0;
   logic [4:0]  aluconf;
   logic        sign, md_busy, md_done;
   logic [31:0] hilo_out;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   brun = 0;
   exp_t scb[$];
   logic [31:0] m_hi = '0, m_lo = '0;

   assign funct_w = rd_hi ? F_MFHI : funct_drv;

   alu_muldiv_ctrl #(.WIDTH(32), .CONF_W(5)) dut (
      .clk      (clk),
      .reset    (reset),
      .ALUOp    (aluop),
      .Funct    (funct_w),
      .start    (start),
      .op_a     (op_a),
      .op_b     (op_b),
      .ALUConf  (aluconf),
      .Sign     (sign),
      .md_busy  (md_busy),
      .md_done  (md_done),
      .hilo_out (hilo_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] exp_conf(input logic [3:0] op, input logic [5:0] f);
      logic [4:0] r;
      r = 5'h00;
      case (op)
         4'd0: r = 5'h00;
         4'd1: r = 5'h01;
         4'd3: r = 5'h02;
         4'd4: r = 5'h10;
         4'd5: r = 5'h08;
         4'd2: begin
            case (f)
               6'h20, 6'h21: r = 5'h00;
               6'h22, 6'h23: r = 5'h01;
               6'h24: r = 5'h02;
               6'h25: r = 5'h03;
               6'h26: r = 5'h04;
               6'h27: r = 5'h05;
               6'h00: r = 5'h06;
               6'h02, 6'h03: r = 5'h07;
               6'h2a, 6'h2b: r = 5'h08;
               6'h08, 6'h09: r = 5'h09;
               default: r = 5'h00;
            endcase
         end
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   function automatic logic exp_sign(input logic [3:0] op, input logic [5:0] f);
      if (op == 4'd6 || op == 4'd7) return 1'b0;
      if (op == 4'd2 && (f == 6'h21 || f == 6'h23 || f == 6'h00 || f == 6'h02 ||
                         f == 6'h2b || f == 6'h19 || f == 6'h1b)) return 1'b0;
      return 1'b1;
   endfunction

   // Reference results from plain integer arithmetic
   function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l);
      longint          p;
      longint unsigned pu;
      int              sa, sd;
      h = '0;
      l = '0;
      if (f == F_MULT) begin
         p = longint'($signed(a)) * longint'($signed(b));
         h = p[63:32];
         l = p[31:0];
      end else if (f == F_MULTU) begin
         pu = {32'h0, a} * {32'h0, b};
         h = pu[63:32];
         l = pu[31:0];
      end else if (b == 32'h0) begin
         l = 32'hFFFF_FFFF;
         h = a;
      end else if (f == F_DIV) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            l = 32'h8000_0000;
            h = 32'h0;
         end else begin
            sa = $signed(a);
            sd = $signed(b);
            l = sa / sd;
            h = sa % sd;
         end
      end else begin
         l = a / b;
         h = a % b;
      end
   endfunction

   // Monitor: each md_done pops one expectation
   always @(negedge clk) begin
      exp_t e;
      if (reset) brun = 0;
      else if (md_busy) brun++;
      else brun = 0;
      if (md_done) begin
         if (scb.size() == 0) begin
            chk("spurious_done", {63'h0, md_done}, 64'h0);
         end else begin
            e = scb.pop_front();
            chk("done_cycle", cyc, e.due);
            chk("busy_len", brun, e.lat);
            chk("lo", hilo_out, e.lo);
            rd_hi = 1'b1;
            #1;
            chk("hi", hilo_out, e.hi);
            rd_hi = 1'b0;
         end
      end
   end

   task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [31:0] h, l;
      @(negedge clk);
      aluop = OP_FUNCT;
      funct_drv = f;
      op_a = a;
      op_b = b;
      start = 1'b1;
      if (f == F_MTHI) m_hi = a;
      else if (f == F_MTLO) m_lo = a;
      else begin
         model(f, a, b, h, l);
         e.hi = h;
         e.lo = l;
         e.lat = ((f == F_DIV || f == F_DIVU) && b == 32'h0) ? 1 : 33;
         e.due = cyc + e.lat;
         scb.push_back(e);
         m_hi = h;
         m_lo = l;
      end
      @(negedge clk);
      start = 1'b0;
      funct_drv = F_MFLO;
      if (f == F_MTHI || f == F_MTLO) begin
         chk("mt_busy", {63'h0, md_busy}, 64'h0);
         chk("mt_lo", hilo_out, m_lo);
         funct_drv = F_MFHI;
         #1;
         chk("mt_hi", hilo_out, m_hi);
         funct_drv = F_MFLO;
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((md_busy || scb.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("wait_timeout", n, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0]  fl[6];
      logic [31:0] a, b;
      fl = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};

      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_busy", {63'h0, md_busy}, 64'h0);
      chk("rst_done", {63'h0, md_done}, 64'h0);
      chk("rst_lo", hilo_out, 64'h0);
      funct_drv = F_MFHI;
      #1;
      chk("rst_hi", hilo_out, 64'h0);

      for (int op = 0; op < 8; op++) begin
         for (int f = 0; f < 64; f++) begin
            aluop = 4'(op);
            funct_drv = 6'(f);
            #1;
            chk("conf", aluconf, exp_conf(4'(op), 6'(f)));
            chk("sign", {63'h0, sign}, {63'h0, exp_sign(4'(op), 6'(f))});
         end
      end
      funct_drv = F_MFLO;

      issue(F_MULT,  32'hFFFF_FFFE, 32'd3);         wait_idle();
      issue(F_MULTU, 32'hFFFF_FFFE, 32'd3);         wait_idle();
      issue(F_DIV,   32'hFFFF_FFF9, 32'd2);         wait_idle();
      issue(F_DIVU,  32'd7,         32'd2);         wait_idle();
      issue(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
      issue(F_DIVU,  32'h0000_1234, 32'd0);         wait_idle();
      issue(F_MTHI,  32'hA5A5_A5A5, 32'd0);
      issue(F_MTLO,  32'h5A5A_0001, 32'd0);

      // start while a divide is running must be ignored
      issue(F_DIV, 32'd1000, 32'hFFFF_FFFD);
      repeat (3) @(negedge clk);
      aluop = OP_FUNCT;
      funct_drv = F_MULT;
      op_a = 32'd9;
      op_b = 32'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      funct_drv = F_MFLO;
      wait_idle();
      repeat (3) @(negedge clk);

      // reset in the middle of a multiply aborts it
      issue(F_MULT, 32'h1234_5678, 32'h0000_0777);
      repeat (8) @(negedge clk);
      scb.delete();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_hi = '0;
      m_lo = '0;
      chk("abort_busy", {63'h0, md_busy}, 64'h0);
      chk("abort_lo", hilo_out, 64'h0);
      funct_drv = F_MFHI;
      #1;
      chk("abort_hi", hilo_out, 64'h0);
      funct_drv = F_MFLO;
      repeat (40) @(negedge clk);
      issue(F_MULT, 32'hFFFF_8000, 32'h0001_0003); wait_idle();

      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'($urandom_range(0, 3));
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: a = 32'($urandom_range(0, 50));
            default: ;
         endcase
         issue(fl[$urandom_range(0, 5)], a, b);
         wait_idle();
      end

      @(negedge clk);
      chk("final_lo", hilo_out, m_lo);
      funct_drv = F_MFHI;
      #1;
      chk("final_hi", hilo_out, m_hi);
      chk("scb_empty", scb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
